fifo_pop_ctrl: RTL and testbench

- Read-side controller for the fifo_6x8 buffer. It pops words from the FIFO and forwards them downstream.
- It holds them in a 2-entry skid buffer so that downstream pause never drops a popped word. It also never over-reads the FIFO.
- It sits between a fifo_6x8 instance and the next pipeline stage of the PCIe switch datapath.

---
 rtl/fifo_pop_ctrl.sv | 116 +++++++++++
 tb/tb_fifo_pop_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_ctrl.sv
// Read-side controller for a fifo_6x8 buffer: pops words without over-reading the FIFO
// and forwards them downstream through a 2-entry skid buffer that absorbs dest_pause.
module fifo_pop_ctrl #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic                 fifo_almost_empty,
    input  logic                 fifo_error,
    input  logic [DATA_SIZE-1:0] data_out_pop,
    input  logic                 dest_pause,
    output logic                 read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [CNT_SIZE-1:0]  pop_count,
    output logic                 err_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_inflight;
    logic [1:0]            r_skid_count;
    logic [DATA_SIZE-1:0]  r_skid_head;
    logic [DATA_SIZE-1:0]  r_skid_tail;
    logic [CNT_SIZE-1:0]   r_pop_count;
    logic                  w_room;
    logic                  w_arrive;

    // Words already popped but not yet delivered must never exceed the skid depth.
    assign w_room   = (r_skid_count + {1'b0, r_inflight}) < 2'd2;
    assign w_arrive = r_inflight;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        read        = 1'b0;
        valid_out   = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (fifo_error) begin
                    w_state_nxt = ST_ERROR;
                end
                // A stale almost-empty flag with a pop in flight may mean the FIFO is already empty.
                read      = !fifo_empty && !fifo_error && w_room &&
                            !(r_inflight && fifo_almost_empty);
                valid_out = (r_skid_count != 2'd0) && !dest_pause;
            end
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_inflight  <= 1'b0;
            r_pop_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= read;
            if (valid_out) begin
                r_pop_count <= r_pop_count + 1'b1;
            end
        end
    end

    // NOTE: the skid storage is reset too; it is only two words and keeps data_out clean after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_count <= 2'd0;
            r_skid_head  <= '0;
            r_skid_tail  <= '0;
        end else begin
            case ({w_arrive, valid_out})
                2'b10: begin
                    if (r_skid_count == 2'd0) begin
                        r_skid_head  <= data_out_pop;
                        r_skid_count <= 2'd1;
                    end else if (r_skid_count == 2'd1) begin
                        r_skid_tail  <= data_out_pop;
                        r_skid_count <= 2'd2;
                    end
                end
                2'b01: begin
                    r_skid_head  <= r_skid_tail;
                    r_skid_count <= r_skid_count - 2'd1;
                end
                2'b11: begin
                    // Arrival and transfer together: occupancy holds, order is preserved.
                    if (r_skid_count == 2'd1) begin
                        r_skid_head <= data_out_pop;
                    end else begin
                        r_skid_head <= r_skid_tail;
                        r_skid_tail <= data_out_pop;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out  = (r_skid_count != 2'd0) ? r_skid_head : '0;
    assign pop_count = r_pop_count;
    assign err_flag  = (r_state == ST_ERROR);

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: a queue-based fifo_6x8 model with a one-pop-stale flag view,
// a scoreboard of expected delivered words, and a monitor that checks every transfer.
module tb_fifo_pop_ctrl;

    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int DEPTH = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_almost_empty = 1'b1;
    wire           fifo_error;
    logic [DW-1:0] data_out_pop = '0;
    logic          dest_pause = 1'b0;
    logic          read;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [CW-1:0] pop_count;
    logic          err_flag;

    logic force_err = 1'b0;
    logic fifo_uf   = 1'b0;
    assign fifo_error = force_err | fifo_uf;

    fifo_pop_ctrl #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_error        (fifo_error),
        .data_out_pop      (data_out_pop),
        .dest_pause        (dest_pause),
        .read              (read),
        .data_out          (data_out),
        .valid_out         (valid_out),
        .pop_count         (pop_count),
        .err_flag          (err_flag)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] wr_q[$];
    logic [DW-1:0] exp_q[$];
    int delivered = 0;
    int n_reads   = 0;
    int n_checks  = 0;
    int n_pass    = 0;
    logic rd_s;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // FIFO model: pops on a sampled read, accepts queued writes, flags lag one pop.
    always @(posedge clk) begin
        int vis;
        rd_s = read;
        #1;
        if (reset) begin
            vis = 0;
            if (rd_s) begin
                n_reads++;
                check("no_underflow", int'(fifo_q.size() != 0), 1);
                if (fifo_q.size() != 0) begin
                    data_out_pop = fifo_q.pop_front();
                    vis = 1;
                end else begin
                    fifo_uf = 1'b1;
                end
            end
            while (wr_q.size() != 0) fifo_q.push_back(wr_q.pop_front());
            vis = vis + fifo_q.size();
            fifo_empty        = (vis == 0);
            fifo_almost_empty = (vis <= 1);
        end
    end

    // Monitor: compares each transfer against the scoreboard and tracks delivered count.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (reset) begin
            check("pop_count", int'(pop_count), delivered % (1 << CW));
            if (valid_out) begin
                check("valid_while_paused", int'(dest_pause), 0);
                check("word_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("data_out", int'(data_out), int'(e));
                end
                delivered++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        fifo_q.delete();
        wr_q.delete();
        exp_q.delete();
        delivered         = 0;
        n_reads           = 0;
        fifo_uf           = 1'b0;
        force_err         = 1'b0;
        fifo_empty        = 1'b1;
        fifo_almost_empty = 1'b1;
        data_out_pop      = '0;
    endtask

    task automatic apply_reset();
        reset      = 1'b0;
        dest_pause = 1'b0;
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        int guard = 0;
        while (fifo_q.size() + wr_q.size() >= DEPTH && guard < 200) begin
            tick();
            guard++;
        end
        if (fifo_q.size() + wr_q.size() >= DEPTH)
            check("push_space_timeout", fifo_q.size() + wr_q.size(), DEPTH - 1);
        else begin
            wr_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check(name, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        int pushed;
        int k;

        // 1: idle after reset with an empty FIFO
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_read", int'(read), 0);
            check("t1_valid", int'(valid_out), 0);
            check("t1_pop_count", int'(pop_count), 0);
        end

        // 2: three words, back-to-back reads limited by almost_empty
        apply_reset();
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        wait_drain("t2_drain", 50);
        repeat (3) tick();
        check("t2_reads", n_reads, 3);
        check("t2_pop_count", int'(pop_count), 3);
        check("t2_fifo_error", int'(fifo_error), 0);

        // 3: paused downstream stops reading at two words outstanding
        apply_reset();
        dest_pause = 1'b1;
        for (int i = 0; i < 6; i++) push_word(8'hC0 + 8'(i));
        repeat (12) tick();
        check("t3_reads_paused", n_reads, 2);
        check("t3_valid_paused", int'(valid_out), 0);
        dest_pause = 1'b0;
        wait_drain("t3_drain", 60);
        check("t3_pop_count", int'(pop_count), 6);
        check("t3_reads_total", n_reads, 6);

        // 4: dest_pause toggling every cycle
        apply_reset();
        for (int i = 0; i < 6; i++) push_word(8'hA0 + 8'(i));
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            dest_pause = ~dest_pause;
            tick();
            k++;
        end
        check("t4_drain", exp_q.size(), 0);
        dest_pause = 1'b0;
        tick();
        check("t4_pop_count", int'(pop_count), 6);

        // Randomized stream with random pause and write gaps
        apply_reset();
        pushed = 0;
        for (int i = 0; i < 60; i++) begin
            dest_pause = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0) begin
                push_word(8'($urandom));
                pushed++;
            end
            tick();
        end
        dest_pause = 1'b0;
        wait_drain("rand_drain", 200);
        check("rand_pop_count", int'(pop_count), pushed % (1 << CW));
        check("rand_no_error", int'(err_flag), 0);

        // 5: FIFO error mid-stream
        apply_reset();
        for (int i = 0; i < 6; i++) push_word(8'h60 + 8'(i));
        repeat (4) tick();
        force_err = 1'b1;
        tick();
        check("t5_read_err", int'(read), 0);
        check("t5_valid_err", int'(valid_out), 0);
        check("t5_err_flag", int'(err_flag), 1);
        force_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_err_sticky", int'(err_flag), 1);
            check("t5_read_stays0", int'(read), 0);
            check("t5_valid_stays0", int'(valid_out), 0);
        end
        reset = 1'b0;
        model_reset();
        #1;
        check("t5_err_cleared", int'(err_flag), 0);
        check("t5_pop_cleared", int'(pop_count), 0);
        tick();
        reset = 1'b1;
        tick();

        // 6: counter wrap, then asynchronous reset mid-transfer
        apply_reset();
        for (int i = 0; i < 17; i++) push_word(8'h80 + 8'(i));
        wait_drain("t6_drain", 300);
        check("t6_pop_wrap", int'(pop_count), 1);
        for (int i = 0; i < 6; i++) push_word(8'h50 + 8'(i));
        k = 0;
        @(negedge clk);
        while (!valid_out && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_valid_seen", int'(valid_out), 1);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("t6_async_read", int'(read), 0);
        check("t6_async_valid", int'(valid_out), 0);
        check("t6_async_data", int'(data_out), 0);
        check("t6_async_pop", int'(pop_count), 0);
        check("t6_async_err", int'(err_flag), 0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("t6_post_reset_valid", int'(valid_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
